// File: rtl/edf_irq_ctrl_if.sv
// rtl/edf_irq_ctrl_if.sv - IC / core handshake bundle for edf_irq_ctrl
interface edf_irq_ctrl_if #(
    parameter int IdWidth    = 2,
    parameter int DlWidth    = 28,
    parameter int DepthWidth = 3
);
    logic                  ic_valid_i;
    logic [IdWidth-1:0]    ic_id_i;
    logic [DlWidth-1:0]    ic_dl_i;
    logic                  ic_ack_o;
    logic [IdWidth-1:0]    ic_ack_id_o;
    logic                  core_irq_o;
    logic [IdWidth-1:0]    core_id_o;
    logic [DlWidth-1:0]    core_dl_o;
    logic                  core_claim_i;
    logic                  core_done_i;
    logic [DepthWidth-1:0] depth_o;
    logic [DlWidth-1:0]    thr_o;
    logic                  err_o;
    logic [15:0]           preempt_cnt_o;

    modport slave (
        input  ic_valid_i, ic_id_i, ic_dl_i, core_claim_i, core_done_i,
        output ic_ack_o, ic_ack_id_o, core_irq_o, core_id_o, core_dl_o,
               depth_o, thr_o, err_o, preempt_cnt_o
    );

    modport master (
        output ic_valid_i, ic_id_i, ic_dl_i, core_claim_i, core_done_i,
        input  ic_ack_o, ic_ack_id_o, core_irq_o, core_id_o, core_dl_o,
               depth_o, thr_o, err_o, preempt_cnt_o
    );
endinterface

// File: rtl/edf_irq_ctrl.sv
// rtl/edf_irq_ctrl.sv - EDF preemption gate between IC and hart, with deadline nesting stack
// Optional nested-preemption counter enabled by EDF_IRQ_CTRL_PREEMPT_CNT_EN.
module edf_irq_ctrl #(
    parameter int NrIrqs    = 4,
    parameter int DlWidth   = 28,
    parameter int NestDepth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    edf_irq_ctrl_if.slave        bus
);
    localparam int IdWidth    = $clog2(NrIrqs);
    localparam int DepthWidth = $clog2(NestDepth + 1);

    typedef enum logic [1:0] {IDLE, OFFER, ACK} state_e;

    state_e                state_q, state_d;
    logic [IdWidth-1:0]    core_id_q, core_id_d;
    logic [DlWidth-1:0]    core_dl_q, core_dl_d;
    logic [DepthWidth-1:0] depth_q, depth_d;
    logic [DlWidth-1:0]    stack_q [NestDepth];
    logic [DlWidth-1:0]    stack_d [NestDepth];
    logic                  err_q, err_d;

    logic [DlWidth-1:0]    thr;
    logic [DlWidth-1:0]    dl_diff;
    logic                  qualify;
    logic                  pop, push;
    logic [DepthWidth-1:0] depth_pop;

    always_comb begin
        thr = '0;
        for (int i = 0; i < NestDepth; i++) begin
            if (int'(depth_q) == i + 1) thr = stack_q[i];
        end
    end

    // Wrap-safe ordering: the sign of the modular difference decides "earlier".
    assign dl_diff = bus.ic_dl_i - thr;
    assign qualify = bus.ic_valid_i && (int'(depth_q) < NestDepth)
                     && ((depth_q == '0) || dl_diff[DlWidth-1]);

    always_comb begin
        state_d   = state_q;
        core_id_d = core_id_q;
        core_dl_d = core_dl_q;
        case (state_q)
            IDLE: begin
                if (qualify) begin
                    core_id_d = bus.ic_id_i;
                    core_dl_d = bus.ic_dl_i;
                    state_d   = OFFER;
                end
            end
            OFFER: begin
                if (bus.core_claim_i) begin
                    state_d = ACK;
                end else if (!qualify || (bus.ic_id_i != core_id_q)
                             || (bus.ic_dl_i != core_dl_q)) begin
                    state_d = IDLE;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pop is applied before push so a same-cycle mret replaces the top entry.
    always_comb begin
        pop       = bus.core_done_i && (depth_q != '0);
        push      = (state_q == ACK);
        depth_pop = depth_q - DepthWidth'(pop);
        depth_d   = depth_pop + DepthWidth'(push);
        stack_d   = stack_q;
        for (int i = 0; i < NestDepth; i++) begin
            if (push && (int'(depth_pop) == i)) stack_d[i] = core_dl_q;
        end
        err_d = err_q
              || (bus.core_done_i && (depth_q == '0))
              || (bus.core_claim_i && (state_q != OFFER));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            core_id_q <= '0;
            core_dl_q <= '0;
            depth_q   <= '0;
            stack_q   <= '{default: '0};
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            core_id_q <= core_id_d;
            core_dl_q <= core_dl_d;
            depth_q   <= depth_d;
            stack_q   <= stack_d;
            err_q     <= err_d;
        end
    end

`ifdef EDF_IRQ_CTRL_PREEMPT_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == ACK) && (depth_q != '0) && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign bus.preempt_cnt_o = cnt_q;
`else
    assign bus.preempt_cnt_o = '0;
`endif

    assign bus.ic_ack_o    = (state_q == ACK);
    assign bus.ic_ack_id_o = (state_q == ACK) ? core_id_q : '0;
    assign bus.core_irq_o  = (state_q == OFFER);
    assign bus.core_id_o   = core_id_q;
    assign bus.core_dl_o   = core_dl_q;
    assign bus.depth_o     = depth_q;
    assign bus.thr_o       = thr;
    assign bus.err_o       = err_q;
endmodule

// File: tb/tb_edf_irq_ctrl.sv
// tb/tb_edf_irq_ctrl.sv - directed scoreboard bench for edf_irq_ctrl
module tb_edf_irq_ctrl;
    localparam int NrIrqs    = 4;
    localparam int DlWidth   = 28;
    localparam int NestDepth = 4;
    localparam int IdWidth    = $clog2(NrIrqs);
    localparam int DepthWidth = $clog2(NestDepth + 1);

`ifdef EDF_IRQ_CTRL_PREEMPT_CNT_EN
    localparam int CntOn = 1;
`else
    localparam int CntOn = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    edf_irq_ctrl_if #(.IdWidth(IdWidth), .DlWidth(DlWidth), .DepthWidth(DepthWidth)) bus ();

    edf_irq_ctrl #(.NrIrqs(NrIrqs), .DlWidth(DlWidth), .NestDepth(NestDepth)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_t;

    sb_t sb[$];
    int  vectors = 0;
    int  miscompares = 0;

    task automatic expect_v(input string tag, input logic [31:0] val);
        sb.push_back('{tag, val});
    endtask

    task automatic chk(input logic [31:0] obs);
        sb_t it;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %0h expected <entry>", obs);
        end else begin
            it = sb.pop_front();
            vectors++;
            assert (obs === it.val) else begin
                miscompares++;
                $error("FAIL %s: observed %0h expected %0h", it.tag, obs, it.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_claim(input logic [IdWidth-1:0] id, input logic [DlWidth-1:0] dl);
        bus.ic_valid_i = 1'b1;
        bus.ic_id_i    = id;
        bus.ic_dl_i    = dl;
        expect_v("claim_offer_irq", 1);
        expect_v("claim_offer_id", 32'(id));
        step();
        chk(32'(bus.core_irq_o));
        chk(32'(bus.core_id_o));
        bus.core_claim_i = 1'b1;
        expect_v("claim_ack", 1);
        expect_v("claim_ack_id", 32'(id));
        step();
        chk(32'(bus.ic_ack_o));
        chk(32'(bus.ic_ack_id_o));
        bus.core_claim_i = 1'b0;
        bus.ic_valid_i   = 1'b0;
        expect_v("claim_ack_gone", 0);
        expect_v("claim_thr", 32'(dl));
        step();
        chk(32'(bus.ic_ack_o));
        chk(32'(bus.thr_o));
    endtask

    initial begin
        bus.ic_valid_i   = 1'b0;
        bus.ic_id_i      = '0;
        bus.ic_dl_i      = '0;
        bus.core_claim_i = 1'b0;
        bus.core_done_i  = 1'b0;
        #12;
        expect_v("rst_irq", 0);   expect_v("rst_ack", 0);  expect_v("rst_depth", 0);
        expect_v("rst_thr", 0);   expect_v("rst_err", 0);  expect_v("rst_cnt", 0);
        chk(32'(bus.core_irq_o)); chk(32'(bus.ic_ack_o));  chk(32'(bus.depth_o));
        chk(32'(bus.thr_o));      chk(32'(bus.err_o));     chk(32'(bus.preempt_cnt_o));
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        // First interrupt on empty stack
        bus.ic_valid_i = 1'b1; bus.ic_id_i = 2; bus.ic_dl_i = 28'h100;
        expect_v("t1_irq", 1); expect_v("t1_id", 2); expect_v("t1_dl", 32'h100);
        step();
        chk(32'(bus.core_irq_o)); chk(32'(bus.core_id_o)); chk(32'(bus.core_dl_o));
        bus.core_claim_i = 1'b1;
        expect_v("t1_ack", 1); expect_v("t1_ack_id", 2); expect_v("t1_irq_ack", 0);
        step();
        chk(32'(bus.ic_ack_o)); chk(32'(bus.ic_ack_id_o)); chk(32'(bus.core_irq_o));
        bus.core_claim_i = 1'b0; bus.ic_valid_i = 1'b0;
        expect_v("t1_ack_one", 0); expect_v("t1_depth", 1); expect_v("t1_thr", 32'h100);
        step();
        chk(32'(bus.ic_ack_o)); chk(32'(bus.depth_o)); chk(32'(bus.thr_o));

        // Nested preemption with strictly earlier deadline
        do_claim(1, 28'h0FF);
        expect_v("t2_depth", 2); expect_v("t2_cnt", 32'(CntOn));
        chk(32'(bus.depth_o)); chk(32'(bus.preempt_cnt_o));
        bus.core_done_i = 1'b1;
        expect_v("t2_pop_depth", 1); expect_v("t2_pop_thr", 32'h100);
        step();
        bus.core_done_i = 1'b0;
        chk(32'(bus.depth_o)); chk(32'(bus.thr_o));

        // Equal and later deadlines never preempt
        bus.ic_valid_i = 1'b1; bus.ic_id_i = 3; bus.ic_dl_i = 28'h100;
        expect_v("t3_equal", 0);
        step(); step();
        chk(32'(bus.core_irq_o));
        bus.ic_dl_i = 28'h200;
        expect_v("t3_later", 0);
        step(); step();
        chk(32'(bus.core_irq_o));
        bus.ic_valid_i = 1'b0;
        bus.core_done_i = 1'b1;
        expect_v("t3_empty", 0);
        step();
        bus.core_done_i = 1'b0;
        chk(32'(bus.depth_o));

        // Wrap-around ordering
        do_claim(0, 28'hFFFFFF0);
        bus.ic_valid_i = 1'b1; bus.ic_id_i = 1; bus.ic_dl_i = 28'h0000010;
        expect_v("wrap_after_not_offered", 0);
        step(); step();
        chk(32'(bus.core_irq_o));
        bus.ic_dl_i = 28'hFFFFFE0;
        expect_v("wrap_before_offered", 1);
        step();
        chk(32'(bus.core_irq_o));
        bus.ic_valid_i = 1'b0;
        expect_v("wrap_withdrawn", 0);
        step();
        chk(32'(bus.core_irq_o));
        bus.core_done_i = 1'b1;
        step();
        bus.core_done_i = 1'b0;

        // Withdraw on id change, then re-offer
        bus.ic_valid_i = 1'b1; bus.ic_id_i = 1; bus.ic_dl_i = 28'h50;
        expect_v("wd_offer1", 1);
        step();
        chk(32'(bus.core_irq_o));
        bus.ic_id_i = 3;
        expect_v("wd_gap", 0); expect_v("wd_reoffer", 1); expect_v("wd_reoffer_id", 3);
        step();
        chk(32'(bus.core_irq_o));
        step();
        chk(32'(bus.core_irq_o)); chk(32'(bus.core_id_o));
        bus.ic_valid_i = 1'b0;
        step();
        bus.ic_valid_i = 1'b1; bus.ic_id_i = 1;
        step();
        bus.ic_id_i = 3; bus.core_claim_i = 1'b1;
        expect_v("claim_wins_ack", 1); expect_v("claim_wins_id", 1);
        step();
        chk(32'(bus.ic_ack_o)); chk(32'(bus.ic_ack_id_o));
        bus.core_claim_i = 1'b0; bus.ic_valid_i = 1'b0;
        expect_v("claim_wins_depth", 1); expect_v("claim_wins_thr", 32'h50);
        step();
        chk(32'(bus.depth_o)); chk(32'(bus.thr_o));

        // Fill the stack
        do_claim(0, 28'h40);
        do_claim(1, 28'h30);
        do_claim(2, 28'h20);
        bus.ic_valid_i = 1'b1; bus.ic_id_i = 0; bus.ic_dl_i = 28'h10;
        expect_v("full_depth", 4); expect_v("full_no_offer", 0);
        step(); step();
        chk(32'(bus.depth_o)); chk(32'(bus.core_irq_o));
        bus.core_done_i = 1'b1;
        expect_v("full_pop_depth", 3); expect_v("full_pop_irq", 0);
        step();
        chk(32'(bus.depth_o)); chk(32'(bus.core_irq_o));
        bus.core_done_i = 1'b0;
        expect_v("resume_offer", 1);
        step();
        chk(32'(bus.core_irq_o));
        bus.ic_valid_i = 1'b0;
        step();
        expect_v("fill_cnt", 32'(CntOn * 4));
        chk(32'(bus.preempt_cnt_o));

        // Drain, then underflow error
        bus.core_done_i = 1'b1;
        step(); step(); step();
        bus.core_done_i = 1'b0;
        expect_v("drain_depth", 0); expect_v("drain_thr", 0); expect_v("drain_err", 0);
        chk(32'(bus.depth_o)); chk(32'(bus.thr_o)); chk(32'(bus.err_o));
        bus.core_done_i = 1'b1;
        expect_v("underflow_err", 1); expect_v("underflow_depth", 0); expect_v("err_sticky", 1);
        step();
        bus.core_done_i = 1'b0;
        chk(32'(bus.err_o)); chk(32'(bus.depth_o));
        step(); step();
        chk(32'(bus.err_o));

        // Asynchronous reset mid-offer
        bus.ic_valid_i = 1'b1; bus.ic_id_i = 2; bus.ic_dl_i = 28'h80;
        expect_v("ar_offer", 1);
        step();
        chk(32'(bus.core_irq_o));
        rst_n = 1'b0;
        #1;
        expect_v("ar_irq", 0); expect_v("ar_err", 0); expect_v("ar_depth", 0);
        chk(32'(bus.core_irq_o)); chk(32'(bus.err_o)); chk(32'(bus.depth_o));
        bus.ic_valid_i = 1'b0;
        step();
        rst_n = 1'b1;
        expect_v("ar_no_ack", 0); expect_v("ar_no_irq", 0);
        step(); step();
        chk(32'(bus.ic_ack_o)); chk(32'(bus.core_irq_o));

        if (sb.size() != 0) begin
            miscompares++;
            $error("FAIL scoreboard_leftover: observed %0d expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/edf_irq_ctrl.md
Name: edf_irq_ctrl

Overview:
- Sits between the EDF interrupt controller and the hart.
- Decides whether the current arbitration winner (id, absolute deadline) may preempt the running context. It offers the interrupt to the core and, on core claim, pulses the IC acknowledge with the claimed id.
- Keeps a stack of active-handler deadlines, so nested interrupts preempt only when their deadline is strictly earlier than the deadline at the top of the stack.

Parameters:
- NrIrqs, 4, number of IC lines; IdWidth = $clog2(NrIrqs) (localparam).
- DlWidth, 28, width of the absolute deadline from the IC (IC TsWidth + TsClip).
- NestDepth, 4, maximum nesting depth; DepthWidth = $clog2(NestDepth+1) (localparam).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- ic_valid_i  in  1  IC has a pending, enabled winner
- ic_id_i  in  IdWidth  IC winner id
- ic_dl_i  in  DlWidth  IC winner absolute deadline
- ic_ack_o  out  1  one-cycle claim pulse to the IC
- ic_ack_id_o  out  IdWidth  id being claimed (valid with ic_ack_o)
- core_irq_o  out  1  interrupt offered to the core
- core_id_o  out  IdWidth  offered id
- core_dl_o  out  DlWidth  offered deadline
- core_claim_i  in  1  core takes the offered interrupt (sampled only while core_irq_o=1)
- core_done_i  in  1  handler return (mret), one-cycle pulse
- depth_o  out  DepthWidth  current nesting depth
- thr_o  out  DlWidth  top-of-stack deadline; 0 when depth_o=0
- err_o  out  1  sticky protocol error
- preempt_cnt_o  out  16  nested-preemption counter (feature-dependent)

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, stack empty.
- Deadline order is wrap-safe: a is earlier than b iff signed(a - b) < 0, computed at DlWidth.
- Qualify = ic_valid_i & (depth_o < NestDepth) & (depth_o == 0 | ic_dl_i earlier than thr_o). Equal deadlines do not preempt.
- FSM states:
  - IDLE: if Qualify, register ic_id_i and ic_dl_i into core_id_o and core_dl_o, go to OFFER. core_irq_o = 1 starting the next cycle.
  - OFFER: core_irq_o = 1.
    - If core_claim_i: go to ACK. Claim wins over any same-cycle change on the IC inputs.
    - Else if !Qualify, or ic_id_i != core_id_o, or ic_dl_i != core_dl_o: deassert core_irq_o and go to IDLE. This is a withdraw with a minimum 1-cycle gap before re-offering.
  - ACK: ic_ack_o = 1 and ic_ack_id_o = core_id_o for exactly 1 cycle; push core_dl_o; core_irq_o = 0; go to IDLE.
- Latency: IC winner to core_irq_o is 1 cycle. Claim to ic_ack_o is 1 cycle. Push is visible on depth_o and thr_o the cycle after ACK.
- Pop: core_done_i with depth_o > 0 decrements depth. thr_o becomes the new top, or 0 when the stack is empty.
- core_done_i while depth_o = 0: ignored and err_o set.
- core_claim_i while core_irq_o = 0: ignored and err_o set.
- core_done_i in the same cycle as the ACK push: pop first, then push. Depth is unchanged and the top is replaced by core_dl_o.
- Stack full (depth_o = NestDepth): nothing is offered. An offer already in OFFER is withdrawn.
- core_done_i in any FSM state updates the stack. If depth drops, Qualify is re-evaluated the next cycle.
- Asynchronous reset mid-offer or mid-ACK: returns to IDLE with the stack empty. No ack pulse is emitted after reset release.
- err_o clears only on reset.

Optional Feature:
- EDF_IRQ_CTRL_PREEMPT_CNT_EN defined: preempt_cnt_o increments on every ACK where depth_o > 0 before the push. It saturates at 16'hFFFF and resets to 0.
- Macro undefined: preempt_cnt_o is tied to 0 and no counter register exists.

Test Plan:
- Empty stack; ic_valid_i=1, id=2, dl=0x100 -> core_irq_o=1 and core_id_o=2 after 1 cycle. Claim -> next cycle ic_ack_o=1 with ic_ack_id_o=2 for 1 cycle. Afterwards depth_o=1 and thr_o=0x100.
- depth_o=1, thr_o=0x100; IC offers dl=0x0FF -> offered and claimed, depth_o=2. Counter = 1 with the macro, 0 without.
- depth_o=1, thr_o=0x100; IC offers dl=0x100, then dl=0x200 -> core_irq_o stays 0 for both.
- Wrap: thr_o=0xFFFFFF0 (DlWidth=28); IC dl=0x0000010 -> not earlier, not offered. IC dl=0xFFFFFE0 -> offered.
- During OFFER of id=1, ic_id_i changes to 3 -> core_irq_o drops for 1 cycle, then id=3 is offered. Claim in the same cycle as the change -> ack for id=1.
- Fill to NestDepth=4 -> no offers. core_done_i -> depth_o=3 and offers resume. core_done_i at depth 0 -> err_o=1 and stays 1.
